// File: rtl/ucie_pkg.sv
// ucie_pkg: shared definitions for the host-side UCIe command link.
//   - ctrl_cmd_t and CMD_* encodings: the host controller command format.
//   - UCIE_PKT_* packet types, header field positions and the header builder.
//   - ucie_tx_state_t: TX serialiser states of ucie_host_initiator.
package ucie_pkg;

  // Host controller command format.
  localparam int CMD_ADDR_W = 32;

  localparam logic [1:0] CMD_NOP    = 2'd0;
  localparam logic [1:0] CMD_MATMUL = 2'd1;
  localparam logic [1:0] CMD_CONV   = 2'd2;

  typedef struct packed {
    logic [1:0]            cmd_type;
    logic [CMD_ADDR_W-1:0] addr_a;
    logic [CMD_ADDR_W-1:0] addr_b;
    logic [15:0]           trans_id;
  } ctrl_cmd_t;

  // Link packet encodings.
  localparam logic [7:0] UCIE_PKT_MATMUL = 8'h01;
  localparam logic [7:0] UCIE_PKT_CONV   = 8'h02;
  localparam logic [7:0] UCIE_PKT_LEN    = 8'd2;  // payload words per packet

  // Header word layout: {type[31:24], len[23:16], trans_id[15:0]}.
  localparam int HDR_TYPE = 24;
  localparam int HDR_LEN  = 16;
  localparam int HDR_TID  = 0;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SEND_HDR,
    TX_SEND_PL0,
    TX_SEND_PL1
  } ucie_tx_state_t;

  // Only MATMUL and CONV ever reach the header state, so anything that is
  // not CONV encodes as MATMUL here.
  function automatic logic [31:0] ucie_build_hdr(input logic [1:0]  cmd_type,
                                                 input logic [15:0] trans_id);
    logic [31:0] hdr;
    hdr = '0;
    hdr[HDR_TYPE +: 8] = (cmd_type == CMD_CONV) ? UCIE_PKT_CONV : UCIE_PKT_MATMUL;
    hdr[HDR_LEN  +: 8] = UCIE_PKT_LEN;
    hdr[HDR_TID  +: 16] = trans_id;
    return hdr;
  endfunction

endpackage

// File: rtl/ucie_id_fifo.sv
// ucie_id_fifo: synchronous FIFO of in-flight transaction IDs.
//   clk, rst_n      : clock, synchronous active-low reset (empties the FIFO)
//   push, push_data : write an ID at the tail
//   pop             : drop the head ID
//   head            : ID at the head (valid when !empty)
//   full, empty     : occupancy flags
//   count           : number of stored IDs
// Push and pop in the same cycle are legal and leave count unchanged.
module ucie_id_fifo #(
  parameter int DEPTH = 8,   // power of two
  parameter int WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Pointers carry one extra MSB: equal pointers mean empty, pointers that
  // differ only in the MSB mean full.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which
  // entries are valid, and a resettable array costs a reset net per bit.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign head  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;

endmodule

// File: rtl/ucie_host_initiator.sv
// ucie_host_initiator: host-side initiator of the UCIe command link.
//   clk, rst_n                    : clock, synchronous active-low reset
//   cmd_valid/cmd_ready/cmd       : host command input (ctrl_cmd_t)
//   tx_valid/tx_ready/tx_data     : link TX words (header, addr_a, addr_b)
//   rx_valid/rx_ready/rx_data     : link RX result words
//   rsp_valid/rsp_ready           : response to host
//   rsp_trans_id/rsp_data/rsp_timeout : retired ID, result (0 on timeout), timeout flag
//   outstanding                   : IDs in flight
//   unsolicited_cnt               : saturating count of RX words with nothing in flight
module ucie_host_initiator
  import ucie_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 8,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               cmd_valid,
  output logic                               cmd_ready,
  input  ctrl_cmd_t                          cmd,
  output logic                               tx_valid,
  input  logic                               tx_ready,
  output logic [DATA_WIDTH-1:0]              tx_data,
  input  logic                               rx_valid,
  output logic                               rx_ready,
  input  logic [DATA_WIDTH-1:0]              rx_data,
  output logic                               rsp_valid,
  input  logic                               rsp_ready,
  output logic [15:0]                        rsp_trans_id,
  output logic [DATA_WIDTH-1:0]              rsp_data,
  output logic                               rsp_timeout,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
  output logic [7:0]                         unsolicited_cnt
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;

  ucie_tx_state_t   state;
  ucie_tx_state_t   state_next;
  ctrl_cmd_t        cmd_reg;

  logic             cmd_hs;
  logic             is_packet;
  logic             rx_hs;
  logic             rsp_free;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [15:0]      fifo_head;
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_terminal;
  logic             tmo_fire;

  // ---------------------------------------------------------------- TX path
  // A full FIFO only blocks new commands: a packet already being sent had its
  // ID slot reserved when it was accepted.
  assign cmd_ready = rst_n && (state == TX_IDLE) && !fifo_full;
  assign cmd_hs    = cmd_valid && cmd_ready;
  assign is_packet = (cmd.cmd_type == CMD_MATMUL) || (cmd.cmd_type == CMD_CONV);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= TX_IDLE;
    else        state <= state_next;
  end

  // NOP and unknown command types are consumed here and never leave IDLE.
  always_ff @(posedge clk) begin
    if (cmd_hs) cmd_reg <= cmd;
  end

  // NOTE: every output of this block gets a default before the case so that
  // no path leaves a signal unassigned and infers a latch.
  always_comb begin
    state_next = state;
    tx_valid   = 1'b0;
    tx_data    = '0;
    fifo_push  = 1'b0;
    unique case (state)
      TX_IDLE: begin
        if (cmd_hs && is_packet) state_next = TX_SEND_HDR;
      end
      TX_SEND_HDR: begin
        tx_valid = 1'b1;
        tx_data  = DATA_WIDTH'(ucie_build_hdr(cmd_reg.cmd_type, cmd_reg.trans_id));
        if (tx_ready) state_next = TX_SEND_PL0;
      end
      TX_SEND_PL0: begin
        tx_valid = 1'b1;
        tx_data  = DATA_WIDTH'(cmd_reg.addr_a);
        if (tx_ready) state_next = TX_SEND_PL1;
      end
      TX_SEND_PL1: begin
        tx_valid = 1'b1;
        tx_data  = DATA_WIDTH'(cmd_reg.addr_b);
        if (tx_ready) begin
          fifo_push  = 1'b1;
          state_next = TX_IDLE;
        end
      end
      default: state_next = TX_IDLE;
    endcase
  end

  // ------------------------------------------------------------- ID FIFO
  ucie_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (16)
  ) u_id_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (cmd_reg.trans_id),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (outstanding)
  );

  // ---------------------------------------------------------- RX / timeout
  assign rsp_free = !rsp_valid || rsp_ready;
  assign rx_ready = rst_n && rsp_free;
  assign rx_hs    = rx_valid && rx_ready;

  // A real result on the terminal cycle takes priority over the timeout.
  assign tmo_terminal = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
  assign tmo_fire     = !fifo_empty && tmo_terminal && rsp_free && !rx_hs;
  assign fifo_pop     = (rx_hs && !fifo_empty) || tmo_fire;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid       <= 1'b0;
      rsp_trans_id    <= '0;
      rsp_data        <= '0;
      rsp_timeout     <= 1'b0;
      tmo_cnt         <= '0;
      unsolicited_cnt <= '0;
    end else begin
      if (fifo_pop) begin
        rsp_valid    <= 1'b1;
        rsp_trans_id <= fifo_head;
        rsp_data     <= rx_hs ? rx_data : '0;
        rsp_timeout  <= !rx_hs;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end

      // Holding at the terminal value keeps the timeout pending while the
      // response register is occupied.
      if (fifo_empty || fifo_pop) tmo_cnt <= '0;
      else if (!tmo_terminal)     tmo_cnt <= tmo_cnt + TMO_W'(1);

      if (rx_hs && fifo_empty && (unsolicited_cnt != 8'hFF))
        unsolicited_cnt <= unsolicited_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_ucie_host_initiator.sv
// tb_ucie_host_initiator: scoreboard bench for ucie_host_initiator.
// Expected TX words and responses are queued when stimulus is driven and
// compared by a negedge monitor when the DUT presents them.
module tb_ucie_host_initiator;
  import ucie_pkg::*;

  localparam int DW  = 32;
  localparam int MO  = 8;
  localparam int TMO = 64;

  logic            clk;
  logic            rst_n;
  logic            cmd_valid;
  logic            cmd_ready;
  ctrl_cmd_t       cmd;
  logic            tx_valid;
  logic            tx_ready;
  logic [DW-1:0]   tx_data;
  logic            rx_valid;
  logic            rx_ready;
  logic [DW-1:0]   rx_data;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [15:0]     rsp_trans_id;
  logic [DW-1:0]   rsp_data;
  logic            rsp_timeout;
  logic [$clog2(MO):0] outstanding;
  logic [7:0]      unsolicited_cnt;

  ucie_host_initiator #(
    .DATA_WIDTH      (DW),
    .MAX_OUTSTANDING (MO),
    .TIMEOUT_CYCLES  (TMO)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd             (cmd),
    .tx_valid        (tx_valid),
    .tx_ready        (tx_ready),
    .tx_data         (tx_data),
    .rx_valid        (rx_valid),
    .rx_ready        (rx_ready),
    .rx_data         (rx_data),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_trans_id    (rsp_trans_id),
    .rsp_data        (rsp_data),
    .rsp_timeout     (rsp_timeout),
    .outstanding     (outstanding),
    .unsolicited_cnt (unsolicited_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] id;
    logic [31:0] data;
    logic        tmo;
  } rsp_t;

  logic [31:0] tx_q[$];
  rsp_t        rsp_q[$];
  logic [15:0] id_model[$];
  int          unsol_exp;
  bit          mon_en;
  rsp_t        exp_rsp;
  int          n_cmp;
  int          n_bad;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: sampled on the falling edge, inputs change just after rising.
  always @(negedge clk) begin
    if (mon_en) begin
      if (tx_valid) begin
        if (tx_q.size() == 0) check("tx_unexpected_valid", tx_valid, 0);
        else begin
          check("tx_word", tx_data, tx_q[0]);
          if (tx_ready) void'(tx_q.pop_front());
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (rsp_q.size() == 0) check("rsp_unexpected_valid", rsp_valid, 0);
        else begin
          exp_rsp = rsp_q.pop_front();
          check("rsp_trans_id", rsp_trans_id, exp_rsp.id);
          check("rsp_data", rsp_data, exp_rsp.data);
          check("rsp_timeout", rsp_timeout, exp_rsp.tmo);
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the rising edge that
  // completed the handshake.
  task automatic send_cmd(input logic [1:0] t, input logic [31:0] a,
                          input logic [31:0] b, input logic [15:0] id);
    int n = 0;
    cmd_valid     = 1'b1;
    cmd.cmd_type  = t;
    cmd.addr_a    = a;
    cmd.addr_b    = b;
    cmd.trans_id  = id;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) check("cmd_accept_wait", cmd_ready, 1);
    else if (t == CMD_MATMUL || t == CMD_CONV) begin
      tx_q.push_back({(t == CMD_CONV) ? 8'h02 : 8'h01, 8'h02, id});
      tx_q.push_back(a);
      tx_q.push_back(b);
      id_model.push_back(id);
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic send_rx(input logic [31:0] d);
    int n = 0;
    rx_valid = 1'b1;
    rx_data  = d;
    @(negedge clk);
    while (!rx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) check("rx_accept_wait", rx_ready, 1);
    else if (id_model.size() != 0) rsp_q.push_back('{id_model.pop_front(), d, 1'b0});
    else if (unsol_exp < 255) unsol_exp++;
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic wait_tx_drain();
    int n = 0;
    while (tx_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("tx_drain", tx_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp_drain();
    int n = 0;
    while (rsp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rsp_drain", rsp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Returns on the falling edge of the first cycle with the given count.
  task automatic wait_outstanding(input int cnt);
    int n = 0;
    @(negedge clk);
    while (outstanding != cnt && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("outstanding_wait", outstanding, cnt);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    n_cmp = 0; n_bad = 0; unsol_exp = 0; mon_en = 0;
    rst_n = 0; cmd_valid = 0; cmd = '0; tx_ready = 1;
    rx_valid = 0; rx_data = '0; rsp_ready = 1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_fields", {rsp_trans_id, rsp_data, 7'd0, rsp_timeout}, 0);
    check("rst_outstanding", outstanding, 0);
    check("rst_unsol", unsolicited_cnt, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_rx_ready", rx_ready, 0);
    @(posedge clk);
    #1 rst_n = 1; mon_en = 1;

    // MATMUL, tx_ready high: three consecutive words, push in N+4
    send_cmd(CMD_MATMUL, 32'h0000_1000, 32'h0000_2000, 16'h0012);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("matmul_tx_valid_seq", tx_valid, 1);
    end
    @(negedge clk);
    check("matmul_outstanding", outstanding, 1);
    check("matmul_cmd_ready_back", cmd_ready, 1);
    @(posedge clk);
    #1 send_rx(32'h0000_BEEF);
    check("rx_to_rsp_latency", rsp_valid, 1);
    wait_rsp_drain();
    check("matmul_drained", outstanding, 0);

    // CONV with tx_ready toggling every cycle
    fork
      send_cmd(CMD_CONV, 32'hA0A0_0001, 32'hB0B0_0002, 16'h0ABC);
      begin
        for (int i = 0; i < 12; i++) begin
          @(posedge clk);
          #1 tx_ready = ~tx_ready;
        end
        tx_ready = 1'b1;
      end
    join
    wait_tx_drain();
    check("conv_outstanding", outstanding, 1);
    send_rx(32'h0000_0C0C);
    wait_rsp_drain();

    // NOP and unknown type are dropped
    send_cmd(CMD_NOP, 32'h1, 32'h2, 16'h0333);
    send_cmd(2'd3, 32'h3, 32'h4, 16'h0444);
    repeat (5) @(negedge clk);
    check("nop_outstanding", outstanding, 0);
    check("nop_no_rsp", rsp_valid, 0);
    @(posedge clk);
    #1;

    // Fill the ID FIFO
    for (int i = 0; i < MO; i++)
      send_cmd(CMD_MATMUL, 32'h0001_0000 + i, 32'h0002_0000 + i, 16'h0100 + 16'(i));
    wait_tx_drain();
    cmd_valid = 1'b1;
    cmd.cmd_type = CMD_CONV;
    cmd.trans_id = 16'h0199;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("full_cmd_ready", cmd_ready, 0);
    end
    check("full_outstanding", outstanding, MO);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    send_rx(32'h0000_DEAD);
    @(negedge clk);
    check("full_cmd_ready_back", cmd_ready, 1);
    check("full_after_pop", outstanding, MO - 1);
    @(posedge clk);
    #1;
    for (int i = 0; i < MO - 1; i++) send_rx(32'h5000 + i);
    wait_rsp_drain();

    // Timeout of a lone transaction
    send_cmd(CMD_MATMUL, 32'h7, 32'h8, 16'h0777);
    void'(id_model.pop_front());
    rsp_q.push_back('{16'h0777, 32'h0, 1'b1});
    wait_outstanding(1);
    k = 0;
    while (!rsp_valid && k < TMO + 20) begin
      @(negedge clk);
      k++;
    end
    check("tmo_latency", k, TMO);
    wait_rsp_drain();
    check("tmo_outstanding", outstanding, 0);

    // RX on the terminal cycle wins over the timeout
    send_cmd(CMD_CONV, 32'h9, 32'hA, 16'h0888);
    wait_outstanding(1);
    repeat (TMO - 2) @(negedge clk);
    @(posedge clk);
    #1 send_rx(32'h0000_CAFE);
    repeat (TMO + 4) @(negedge clk);
    check("term_outstanding", outstanding, 0);
    check("term_rsp_q", rsp_q.size(), 0);
    @(posedge clk);
    #1;

    // Unsolicited RX words
    send_rx(32'h0000_0001);
    @(negedge clk);
    check("unsol_one", unsolicited_cnt, 1);
    check("unsol_no_rsp", rsp_valid, 0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 299; i++) send_rx(32'h100 + i);
    @(negedge clk);
    check("unsol_sat", unsolicited_cnt, 255);
    check("unsol_model", unsolicited_cnt, unsol_exp);
    @(posedge clk);
    #1;

    // Response backpressure
    rsp_ready = 1'b0;
    send_cmd(CMD_MATMUL, 32'hB, 32'hC, 16'h0A01);
    send_cmd(CMD_CONV, 32'hD, 32'hE, 16'h0A02);
    wait_tx_drain();
    send_rx(32'h0000_1111);
    check("bp_first_rsp", rsp_valid, 1);
    rx_valid = 1'b1;
    rx_data  = 32'h0000_2222;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_rx_ready_low", rx_ready, 0);
      check("bp_hold_id", rsp_trans_id, 16'h0A01);
      check("bp_hold_data", rsp_data, 32'h0000_1111);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    send_rx(32'h0000_2222);
    wait_rsp_drain();
    check("bp_outstanding", outstanding, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
